sector_pulse_tracker: RTL and testbench
=======================================

// Module: sector_pulse_tracker
// PURPOSE
//  Controller-side receiver for the drive's sector/index strobes (2.5 MHz domain).
//  - Qualifies the strobes and locks to the index.
//  - Tracks the current sector number (0..SECTORS-1) and checks sector-to-sector timing.
//  - Flags missing, early or late pulses so the disk controller can wait for a target sector.
// PARAMETERS
//  SECTORS        16    sectors per revolution; index coincides with sector 0 strobe
//  SECTOR_PERIOD  3906  nominal clk25 cycles between sector strobes
//  TOL            64    allowed +/- deviation of measured period, in cycles
//  MIN_PULSE      8     consecutive high cycles needed to accept a strobe (glitch filter)
// PORTS
//  clk25          in   1   2.5 MHz clock
//  reset          in   1   synchronous, active-high
//  sector_strobe  in   1   drive sector strobe, high ~120 cycles per sector
//  index_strobe   in   1   drive index strobe, high only during sector 0 strobe
//  sector         out  4   current sector number, valid when locked=1
//  locked         out  1   tracker synchronised to index
//  sector_start   out  1   1-cycle pulse: new sector accepted while locked
//  rev_start      out  1   1-cycle pulse: index accepted (coincides with sector_start when locked)
//  err_timing     out  1   1-cycle pulse: accepted interval outside SECTOR_PERIOD+/-TOL
//  err_index      out  1   1-cycle pulse: index missing after sector SECTORS-1, or index early
//  err_timeout    out  1   1-cycle pulse: no strobe for SECTOR_PERIOD+TOL cycles while locked
// BEHAVIOUR
//  - Reset: sector=0; locked, all pulse outputs, width counter and interval counter = 0; state HUNT.
//  - Width counter:
//    - Counts cycles with sector_strobe=1, saturating at MIN_PULSE.
//    - Clears when sector_strobe=0.
//  - Acceptance:
//    - A strobe is accepted in the single cycle where the width counter reaches MIN_PULSE,
//      i.e. latency MIN_PULSE cycles from the first high sample.
//    - Shorter pulses are ignored and do not disturb the interval counter.
//  - Index qualification:
//    - An accepted strobe is an index if index_strobe=1 in the acceptance cycle.
//    - index_strobe without sector_strobe is ignored.
//  - Interval counter:
//    - Cleared to 1 on acceptance, else +1.
//    - Saturates at SECTOR_PERIOD+TOL+1; width $clog2(SECTOR_PERIOD+TOL+2).
//  - FSM HUNT:
//    - On accepted index: sector<=0, locked<=1, rev_start=1, sector_start=1, go LOCKED.
//    - No interval check is made on the first lock.
//    - Non-index strobes are ignored.
//  - FSM LOCKED, on accepted strobe with interval outside [PERIOD-TOL, PERIOD+TOL]:
//    - err_timing=1, locked<=0, go HUNT.
//    - This check takes priority over the index checks below.
//  - FSM LOCKED, non-index strobe, sector<SECTORS-1: sector<=sector+1, sector_start=1.
//  - FSM LOCKED, non-index strobe, sector==SECTORS-1: err_index=1, locked<=0, go HUNT.
//  - FSM LOCKED, index strobe, sector==SECTORS-1: sector<=0, sector_start=1, rev_start=1.
//  - FSM LOCKED, index strobe, sector!=SECTORS-1:
//    - err_index=1, sector<=0, sector_start=1, rev_start=1.
//    - Stays LOCKED (resync).
//  - FSM LOCKED, timeout:
//    - When the interval counter reaches PERIOD+TOL+1 with no acceptance: err_timeout=1
//      (once), locked<=0, go HUNT.
//  - The sector output holds its value in HUNT and is don't-care while locked=0.
//  - Reset mid-pulse: the pulse in progress is not accepted; it must restart from low.
// CONFIGURATION
//  - SECTOR_INPUT_SYNC_EN defined:
//    - Both strobes pass through 2-flop synchronisers (reset to 0) before all logic.
//    - All latencies +2 cycles.
//  - SECTOR_INPUT_SYNC_EN not defined: strobes are used directly (same clock domain as the drive model).
// STRUCTURE
//  - Package sector_pkg:
//    - typedef enum logic {HUNT, LOCKED} sect_state_t.
//    - Default constants SECTORS_DEF=16, SECTOR_PERIOD_DEF=3906, SECTOR_PULSE_W=120.
//    - typedef logic[3:0] sector_t.
//  - One sub-module strobe_qualifier:
//    - Contains the optional sync stage and the width counter.
//    - Outputs accept and is_index.
// TESTING
//  - Drive model: period 3906, pulse 120, index on sector 0, start mid-rev at sector 5.
//    - No sector_start until index.
//    - Then locked=1 and sector 0,1..15,0 with sector_start every 3906 cycles.
//    - No errors over 3 revolutions.
//  - 5-cycle sector_strobe glitch 1000 cycles after acceptance:
//    - Ignored; sector unchanged; the next real strobe still passes the timing check.
//  - Drop the index on sector 0 while locked at sector 15:
//    - err_index pulse, locked=0.
//    - Relock on the next index.
//  - Sector strobe arriving 3800 cycles after the previous one: err_timing, locked=0.
//  - Remove strobes while locked: err_timeout exactly 3971 cycles after the last acceptance, locked=0.
//  - Index injected at sector 7: err_index, sector=0, locked stays 1.
//  - Reset asserted at cycle 50 of a pulse: all outputs 0; that pulse is not accepted.

Source files
------------

// File: rtl/sector_pkg.sv
// Shared types and default geometry for the sector/index strobe tracker.
// Optional input synchroniser is selected with SECTOR_INPUT_SYNC_EN (see strobe_qualifier).
package sector_pkg;

    typedef enum logic {HUNT, LOCKED} sect_state_t;

    typedef logic [3:0] sector_t;

    localparam int SECTORS_DEF       = 16;
    localparam int SECTOR_PERIOD_DEF = 3906;
    localparam int SECTOR_PULSE_W    = 120;

endpackage

// File: rtl/strobe_qualifier.sv
// Glitch filter for the drive strobes: accept fires once per pulse after MIN_PULSE high samples.
// Latency MIN_PULSE cycles (+2 with SECTOR_INPUT_SYNC_EN); no backpressure, strobes are free-running.
module strobe_qualifier #(
    parameter int MIN_PULSE = 8
) (
    input  logic clk25,
    input  logic reset,
    input  logic sector_strobe_i,
    input  logic index_strobe_i,
    output logic accept_o,
    output logic is_index_o
);

    localparam int WW = $clog2(MIN_PULSE + 1);
    localparam logic [WW-1:0] WMAX  = WW'(MIN_PULSE);
    localparam logic [WW-1:0] WLAST = WW'(MIN_PULSE - 1);

    logic          sec_s;
    logic          idx_s;
    logic          sample_ok;
    logic [WW-1:0] width_q, width_d;
    logic          armed_q, armed_d;

`ifdef SECTOR_INPUT_SYNC_EN
    logic [1:0] sec_sync_q;
    logic [1:0] idx_sync_q;
    logic [1:0] prime_q;

    always_ff @(posedge clk25) begin
        if (reset) begin
            sec_sync_q <= 2'b00;
            idx_sync_q <= 2'b00;
            prime_q    <= 2'b00;
        end else begin
            sec_sync_q <= {sec_sync_q[0], sector_strobe_i};
            idx_sync_q <= {idx_sync_q[0], index_strobe_i};
            prime_q    <= {prime_q[0], 1'b1};
        end
    end

    assign sec_s     = sec_sync_q[1];
    assign idx_s     = idx_sync_q[1];
    // The reset-zeroed pipeline must flush before a low sample is trusted.
    assign sample_ok = prime_q[1];
`else
    assign sec_s     = sector_strobe_i;
    assign idx_s     = index_strobe_i;
    assign sample_ok = 1'b1;
`endif

    // A pulse already high when reset releases is never counted: arm only after a low.
    always_comb begin
        armed_d = armed_q;
        width_d = width_q;
        if (!sec_s) begin
            width_d = '0;
            if (sample_ok) armed_d = 1'b1;
        end else if (armed_q && width_q != WMAX) begin
            width_d = width_q + WW'(1);
        end
    end

    always_ff @(posedge clk25) begin
        if (reset) begin
            width_q <= '0;
            armed_q <= 1'b0;
        end else begin
            width_q <= width_d;
            armed_q <= armed_d;
        end
    end

    assign accept_o   = armed_q && sec_s && (width_q == WLAST);
    assign is_index_o = accept_o && idx_s;

endmodule

// File: rtl/sector_pulse_tracker.sv
// Locks to the drive index, tracks the sector number and flags timing/index/timeout faults.
// Outputs registered one cycle after acceptance; no backpressure. Input sync via SECTOR_INPUT_SYNC_EN.
module sector_pulse_tracker
    import sector_pkg::*;
#(
    parameter int SECTORS       = SECTORS_DEF,
    parameter int SECTOR_PERIOD = SECTOR_PERIOD_DEF,
    parameter int TOL           = 64,
    parameter int MIN_PULSE     = 8
) (
    input  logic    clk25,
    input  logic    reset,
    input  logic    sector_strobe,
    input  logic    index_strobe,
    output sector_t sector,
    output logic    locked,
    output logic    sector_start,
    output logic    rev_start,
    output logic    err_timing,
    output logic    err_index,
    output logic    err_timeout
);

    localparam int CW = $clog2(SECTOR_PERIOD + TOL + 2);
    localparam logic [CW-1:0] IMAX = CW'(SECTOR_PERIOD + TOL + 1);
    localparam logic [CW-1:0] ILO  = CW'(SECTOR_PERIOD - TOL);
    localparam logic [CW-1:0] IHI  = CW'(SECTOR_PERIOD + TOL);
    localparam sector_t       LAST = sector_t'(SECTORS - 1);

    logic accept;
    logic is_index;

    strobe_qualifier #(
        .MIN_PULSE (MIN_PULSE)
    ) u_qual (
        .clk25           (clk25),
        .reset           (reset),
        .sector_strobe_i (sector_strobe),
        .index_strobe_i  (index_strobe),
        .accept_o        (accept),
        .is_index_o      (is_index)
    );

    logic [CW-1:0] interval_q, interval_d;
    sect_state_t   state_q, state_d;
    sector_t       sector_q, sector_d;
    logic          locked_q, locked_d;
    logic          ss_q, ss_d, rs_q, rs_d;
    logic          etim_q, etim_d, eidx_q, eidx_d, eto_q, eto_d;
    logic          in_range;
    logic          timeout_hit;

    // Interval reads as the true strobe-to-strobe distance in the acceptance cycle.
    always_comb begin
        if (accept)                interval_d = CW'(1);
        else if (interval_q == IMAX) interval_d = interval_q;
        else                       interval_d = interval_q + CW'(1);
    end

    assign in_range    = (interval_q >= ILO) && (interval_q <= IHI);
    assign timeout_hit = !accept && (interval_d == IMAX) && (interval_q != IMAX);

    always_comb begin
        state_d  = state_q;
        sector_d = sector_q;
        locked_d = locked_q;
        ss_d     = 1'b0;
        rs_d     = 1'b0;
        etim_d   = 1'b0;
        eidx_d   = 1'b0;
        eto_d    = 1'b0;
        case (state_q)
            HUNT: begin
                if (accept && is_index) begin
                    sector_d = '0;
                    locked_d = 1'b1;
                    ss_d     = 1'b1;
                    rs_d     = 1'b1;
                    state_d  = LOCKED;
                end
            end
            LOCKED: begin
                if (accept) begin
                    if (!in_range) begin
                        etim_d   = 1'b1;
                        locked_d = 1'b0;
                        state_d  = HUNT;
                    end else if (is_index) begin
                        // An early index resynchronises rather than dropping lock.
                        sector_d = '0;
                        ss_d     = 1'b1;
                        rs_d     = 1'b1;
                        eidx_d   = (sector_q != LAST);
                    end else if (sector_q == LAST) begin
                        eidx_d   = 1'b1;
                        locked_d = 1'b0;
                        state_d  = HUNT;
                    end else begin
                        sector_d = sector_q + sector_t'(1);
                        ss_d     = 1'b1;
                    end
                end else if (timeout_hit) begin
                    eto_d    = 1'b1;
                    locked_d = 1'b0;
                    state_d  = HUNT;
                end
            end
            default: begin
                state_d  = HUNT;
                locked_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk25) begin
        if (reset) begin
            state_q    <= HUNT;
            interval_q <= '0;
            sector_q   <= '0;
            locked_q   <= 1'b0;
            ss_q       <= 1'b0;
            rs_q       <= 1'b0;
            etim_q     <= 1'b0;
            eidx_q     <= 1'b0;
            eto_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            interval_q <= interval_d;
            sector_q   <= sector_d;
            locked_q   <= locked_d;
            ss_q       <= ss_d;
            rs_q       <= rs_d;
            etim_q     <= etim_d;
            eidx_q     <= eidx_d;
            eto_q      <= eto_d;
        end
    end

    assign sector       = sector_q;
    assign locked       = locked_q;
    assign sector_start = ss_q;
    assign rev_start    = rs_q;
    assign err_timing   = etim_q;
    assign err_index    = eidx_q;
    assign err_timeout  = eto_q;

endmodule

// File: tb/tb_sector_pulse_tracker.sv
// Directed bench for sector_pulse_tracker with a shortened sector period to keep runs short.
module tb_sector_pulse_tracker;

    localparam int P  = 300;
    localparam int T  = 16;
    localparam int W  = 20;
    localparam int MP = 8;

    logic       clk25 = 1'b0;
    logic       reset = 1'b1;
    logic       sector_strobe = 1'b0;
    logic       index_strobe = 1'b0;
    logic [3:0] sector;
    logic       locked, sector_start, rev_start, err_timing, err_index, err_timeout;

    sector_pulse_tracker #(
        .SECTORS       (16),
        .SECTOR_PERIOD (P),
        .TOL           (T),
        .MIN_PULSE     (MP)
    ) dut (
        .clk25         (clk25),
        .reset         (reset),
        .sector_strobe (sector_strobe),
        .index_strobe  (index_strobe),
        .sector        (sector),
        .locked        (locked),
        .sector_start  (sector_start),
        .rev_start     (rev_start),
        .err_timing    (err_timing),
        .err_index     (err_index),
        .err_timeout   (err_timeout)
    );

    always #5 clk25 = ~clk25;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc = 0;
    int n_ss = 0, n_rs = 0, n_et = 0, n_ei = 0, n_eto = 0, seq_bad = 0;
    int t_ss = 0, t_to = 0;
    int exp_sec = 0;
    int b_ss, b_rs, b_et, b_ei, b_eto;

    always @(posedge clk25) cyc <= cyc + 1;

    always @(negedge clk25) begin
        if (sector_start) begin
            n_ss++;
            t_ss = cyc;
            if (int'(sector) != exp_sec) seq_bad++;
        end
        if (rev_start)   n_rs++;
        if (err_timing)  n_et++;
        if (err_index)   n_ei++;
        if (err_timeout) begin
            n_eto++;
            t_to = cyc;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk25);
    endtask

    task automatic pulse(input bit idx, input int w);
        sector_strobe = 1'b1;
        index_strobe  = idx;
        idle(w);
        sector_strobe = 1'b0;
        index_strobe  = 1'b0;
    endtask

    task automatic sect(input bit idx);
        pulse(idx, W);
        idle(P - W);
    endtask

    task automatic snap();
        b_ss = n_ss; b_rs = n_rs; b_et = n_et; b_ei = n_ei; b_eto = n_eto;
    endtask

    initial begin
        idle(4);
        check("rst_sector", int'(sector), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_pulses", int'({sector_start, rev_start, err_timing, err_index, err_timeout}), 0);
        reset = 1'b0;
        idle(3);

        // Start mid-revolution at sector 5: nothing until the index.
        for (int s = 5; s < 16; s++) sect(1'b0);
        check("hunt_no_start", n_ss, 0);
        check("hunt_unlocked", int'(locked), 0);

        for (int r = 0; r < 3; r++) begin
            exp_sec = 0;
            sect(1'b1);
            for (int s = 1; s < 16; s++) begin
                exp_sec = s;
                sect(1'b0);
            end
        end
        exp_sec = 0;
        sect(1'b1);
        check("rev_ss_count", n_ss, 49);
        check("rev_rs_count", n_rs, 4);
        check("rev_no_errors", n_et + n_ei + n_eto, 0);
        check("rev_locked", int'(locked), 1);
        check("rev_sector", int'(sector), 0);

        // Short glitch between sectors 1 and 2.
        snap();
        exp_sec = 1;
        pulse(1'b0, W);
        idle(80);
        pulse(1'b0, 5);
        idle(195);
        check("glitch_sector", int'(sector), 1);
        check("glitch_ss", n_ss - b_ss, 1);
        exp_sec = 2;
        sect(1'b0);
        check("glitch_next_ok", n_et - b_et, 0);
        check("glitch_next_sec", int'(sector), 2);

        // Index missing after sector 15.
        for (int s = 3; s < 16; s++) begin
            exp_sec = s;
            sect(1'b0);
        end
        snap();
        sect(1'b0);
        check("noidx_err", n_ei - b_ei, 1);
        check("noidx_unlocked", int'(locked), 0);
        check("noidx_no_start", n_ss - b_ss, 0);
        exp_sec = 0;
        sect(1'b1);
        check("relock_locked", int'(locked), 1);
        check("relock_rev", n_rs - b_rs, 1);

        // Early strobe: 260 cycles after sector 1.
        snap();
        exp_sec = 1;
        pulse(1'b0, W);
        idle(260 - W);
        pulse(1'b0, W);
        idle(P - W);
        check("early_err", n_et - b_et, 1);
        check("early_unlocked", int'(locked), 0);
        check("early_ss", n_ss - b_ss, 1);
        check("early_hold_sec", int'(sector), 1);

        // Strobes stop after a fresh lock.
        snap();
        exp_sec = 0;
        sect(1'b1);
        idle(400);
        check("to_count", n_eto - b_eto, 1);
        check("to_unlocked", int'(locked), 0);
        check("to_delay", t_to - t_ss, P + T);
        check("to_no_timing", n_et - b_et, 0);

        // Index injected at sector 7 resyncs without losing lock.
        snap();
        exp_sec = 0;
        sect(1'b1);
        for (int s = 1; s < 7; s++) begin
            exp_sec = s;
            sect(1'b0);
        end
        exp_sec = 0;
        sect(1'b1);
        check("inj_err", n_ei - b_ei, 1);
        check("inj_locked", int'(locked), 1);
        check("inj_sector", int'(sector), 0);
        check("inj_rev", n_rs - b_rs, 2);
        check("inj_ss", n_ss - b_ss, 8);

        // Reset lands 50 cycles into a long index pulse.
        exp_sec = 0;
        sector_strobe = 1'b1;
        index_strobe  = 1'b1;
        idle(50);
        reset = 1'b1;
        idle(2);
        check("mid_rst_sector", int'(sector), 0);
        check("mid_rst_locked", int'(locked), 0);
        check("mid_rst_pulses", int'({sector_start, rev_start, err_timing, err_index, err_timeout}), 0);
        reset = 1'b0;
        idle(1);
        snap();
        idle(67);
        sector_strobe = 1'b0;
        index_strobe  = 1'b0;
        idle(100);
        check("mid_rst_ignored", n_ss - b_ss, 0);
        check("mid_rst_unlock", int'(locked), 0);
        sect(1'b1);
        check("post_rst_lock", int'(locked), 1);
        check("post_rst_ss", n_ss - b_ss, 1);

        check("sector_sequence", seq_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
